// File: rtl/icache_pkg.sv
// icache_pkg: shared widths and FSM encodings for the instruction cache.
//   ICacheIndexBits  log2(number of lines), one 32-bit instruction per line
//   ICacheAddrBits   physical address bits covered by the tag
//   ICacheTagBits    tag width derived from the two above
//   InstAddrBus      fetch address width
//   InstBus          instruction width
//   STATE_IDLE/MISS  controller state encodings
package icache_pkg;

    localparam int ICacheIndexBits = 7;
    localparam int ICacheAddrBits  = 18;
    localparam int ICacheTagBits   = ICacheAddrBits - ICacheIndexBits - 2;
    localparam int InstAddrBus     = 32;
    localparam int InstBus         = 32;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_MISS = 1'b1;

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped icache.
//   clk, rst                  clock; synchronous active-high reset clears valid bits
//   rd_index                  combinational read address
//   rd_valid, rd_tag, rd_data line contents at rd_index
//   wr_en, wr_index           synchronous write strobe and address
//   wr_tag, wr_data           line contents to store; sets the valid bit
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICacheIndexBits,
    parameter int TAG_BITS   = ICacheTagBits,
    parameter int DATA_BITS  = InstBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_BITS-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_BITS-1:0]  wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags [LINES];
    logic [DATA_BITS-1:0] data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between IF and mem_control.
//   clk, rst             clock; synchronous active-high reset
//   if_req_i, pc_i       IF fetch request and address (word aligned)
//   inst_o, inst_valid_o instruction for IF and its valid flag
//   branch_interception  flush: abandon any outstanding miss
//   inst_needed          fetch request to mem_control (held through a miss)
//   inst_addr_o          fetch address to mem_control
//   inst_available       one-cycle pulse from mem_control, inst_i valid
//   inst_i               fetched word
// Hits answer combinationally in IDLE. A miss captures pc_i, holds the
// request until a fill or a flush, and forwards the fill to IF when IF is
// still asking for the same address.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICacheIndexBits,
    parameter int ADDR_BITS  = ICacheAddrBits
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] pc_i,
    output logic [InstBus-1:0]     inst_o,
    output logic                   inst_valid_o,
    input  logic                   branch_interception,
    output logic                   inst_needed,
    output logic [InstAddrBus-1:0] inst_addr_o,
    input  logic                   inst_available,
    input  logic [InstBus-1:0]     inst_i
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    logic [0:0]             state;
    logic [InstAddrBus-1:0] miss_addr;

    logic [INDEX_BITS-1:0]  pc_index;
    logic [TAG_BITS-1:0]    pc_tag;
    logic                   line_valid;
    logic [TAG_BITS-1:0]    line_tag;
    logic [InstBus-1:0]     line_data;
    logic                   hit;
    logic                   fill;

    assign pc_index = pc_i[INDEX_BITS+1:2];
    assign pc_tag   = pc_i[ADDR_BITS-1:INDEX_BITS+2];
    assign hit      = if_req_i & line_valid & (line_tag == pc_tag);
    // A fill that coincides with a flush is still written: the word belongs
    // to miss_addr regardless of where the pipeline is heading.
    assign fill     = (state == STATE_MISS) & inst_available & ~rst;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_BITS  (InstBus)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill),
        .wr_index (miss_addr[INDEX_BITS+1:2]),
        .wr_tag   (miss_addr[ADDR_BITS-1:INDEX_BITS+2]),
        .wr_data  (inst_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STATE_IDLE;
            miss_addr   <= '0;
            inst_needed <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (if_req_i && !hit && !branch_interception) begin
                        state       <= STATE_MISS;
                        miss_addr   <= pc_i;
                        inst_needed <= 1'b1;
                    end
                end
                STATE_MISS: begin
                    if (inst_available || branch_interception) begin
                        state       <= STATE_IDLE;
                        inst_needed <= 1'b0;
                    end
                end
                default: begin
                    state       <= STATE_IDLE;
                    inst_needed <= 1'b0;
                end
            endcase
        end
    end

    // miss_addr is captured exactly when the fetch address must change, so it
    // doubles as the registered inst_addr_o.
    assign inst_addr_o = miss_addr;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = '0;
        if (!rst && !branch_interception) begin
            if (state == STATE_IDLE) begin
                if (hit) begin
                    inst_valid_o = 1'b1;
                    inst_o       = line_data;
                end
            end else if (inst_available && if_req_i && (pc_i == miss_addr)) begin
                inst_valid_o = 1'b1;
                inst_o       = inst_i;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 time unit after that, well clear of the next edge.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        branch_interception;
    logic        inst_needed;
    logic [31:0] inst_addr_o;
    logic        inst_available;
    logic [31:0] inst_i;

    int errors = 0;
    int checks = 0;

    icache #(
        .INDEX_BITS (7),
        .ADDR_BITS  (18)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_req_i            (if_req_i),
        .pc_i                (pc_i),
        .inst_o              (inst_o),
        .inst_valid_o        (inst_valid_o),
        .branch_interception (branch_interception),
        .inst_needed         (inst_needed),
        .inst_addr_o         (inst_addr_o),
        .inst_available      (inst_available),
        .inst_i              (inst_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                 = 1'b1;
        if_req_i            = 1'b0;
        pc_i                = '0;
        branch_interception = 1'b0;
        inst_available      = 1'b0;
        inst_i              = '0;
        tick();
        tick();
        #1;
        check("rst_needed", {31'd0, inst_needed}, 32'd0);
        check("rst_addr",   inst_addr_o,           32'd0);
        check("rst_valid",  {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst",   inst_o,                32'd0);
        rst = 1'b0;
        tick();

        // 1. Cold miss on 0x100, fill forwarded the same cycle.
        if_req_i = 1'b1;
        pc_i     = 32'h100;
        #1;
        check("cold_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        pc_i = 32'h500;   // must be ignored while the miss is outstanding
        #1;
        check("cold_needed", {31'd0, inst_needed}, 32'd1);
        check("cold_addr",   inst_addr_o,           32'h100);
        check("cold_nofwd",  {31'd0, inst_valid_o}, 32'd0);
        tick();
        check("hold_needed", {31'd0, inst_needed}, 32'd1);
        check("hold_addr",   inst_addr_o,           32'h100);
        pc_i           = 32'h100;
        inst_available = 1'b1;
        inst_i         = 32'h00A00093;
        #1;
        check("fwd_valid", {31'd0, inst_valid_o}, 32'd1);
        check("fwd_inst",  inst_o,                32'h00A00093);
        tick();
        inst_available = 1'b0;
        inst_i         = 32'hFFFF_FFFF;
        #1;
        check("fill_needed_low", {31'd0, inst_needed}, 32'd0);

        // 2. Re-hit on 0x100 in the same cycle, no new fetch.
        check("rehit_valid", {31'd0, inst_valid_o}, 32'd1);
        check("rehit_inst",  inst_o,                32'h00A00093);
        tick();
        check("rehit_needed", {31'd0, inst_needed}, 32'd0);

        // 3. Conflict: 0x300 shares index 0x40 with 0x100.
        pc_i = 32'h300;
        #1;
        check("conf_miss", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check("conf_needed", {31'd0, inst_needed}, 32'd1);
        check("conf_addr",   inst_addr_o,           32'h300);
        inst_available = 1'b1;
        inst_i         = 32'h1111_1111;
        #1;
        check("conf_fwd", inst_o, 32'h1111_1111);
        tick();
        inst_available = 1'b0;
        #1;
        check("conf_hit", inst_o, 32'h1111_1111);
        pc_i = 32'h100;
        #1;
        check("evicted_miss", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check("evicted_addr", inst_addr_o, 32'h100);
        inst_available = 1'b1;
        inst_i         = 32'h00A00093;
        tick();
        inst_available = 1'b0;

        // 4. Flush two cycles into a miss on 0x200; late pulse ignored.
        pc_i = 32'h200;
        tick();
        check("flush_needed0", {31'd0, inst_needed}, 32'd1);
        tick();
        branch_interception = 1'b1;
        #1;
        check("flush_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        branch_interception = 1'b0;
        if_req_i            = 1'b0;
        #1;
        check("flush_needed", {31'd0, inst_needed}, 32'd0);
        inst_available = 1'b1;
        inst_i         = 32'hDEAD_BEEF;
        tick();
        inst_available = 1'b0;
        if_req_i       = 1'b1;
        #1;
        check("late_nowrite", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check("refetch_addr", inst_addr_o, 32'h200);
        inst_available = 1'b1;
        inst_i         = 32'h2222_2222;
        tick();
        inst_available = 1'b0;
        #1;
        check("refetch_hit", inst_o, 32'h2222_2222);

        // 5. Fill and flush in the same cycle on 0x204.
        pc_i = 32'h204;
        tick();
        check("ff_needed", {31'd0, inst_needed}, 32'd1);
        inst_available      = 1'b1;
        branch_interception = 1'b1;
        inst_i              = 32'h3333_3333;
        #1;
        check("ff_nofwd", {31'd0, inst_valid_o}, 32'd0);
        tick();
        inst_available      = 1'b0;
        branch_interception = 1'b0;
        #1;
        check("ff_needed_low", {31'd0, inst_needed}, 32'd0);
        check("ff_hit",        inst_o,                32'h3333_3333);
        branch_interception = 1'b1;   // flush in IDLE masks even a hit
        #1;
        check("idle_flush_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        branch_interception = 1'b0;
        #1;
        check("idle_flush_nomiss", {31'd0, inst_needed}, 32'd0);

        // 6. rst during a miss invalidates everything.
        pc_i = 32'h100;
        #1;
        check("pre_rst_hit", {31'd0, inst_valid_o}, 32'd1);
        pc_i = 32'h800;
        tick();
        check("rstmiss_needed", {31'd0, inst_needed}, 32'd1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        if_req_i = 1'b0;
        #1;
        check("rstmiss_needed_low", {31'd0, inst_needed}, 32'd0);
        check("rstmiss_addr",       inst_addr_o,           32'd0);
        inst_available = 1'b1;
        inst_i         = 32'hBAD0_BAD0;
        tick();
        inst_available = 1'b0;
        if_req_i       = 1'b1;
        pc_i           = 32'h100;
        #1;
        check("post_rst_miss", {31'd0, inst_valid_o}, 32'd0);
        tick();
        check("post_rst_fetch", {31'd0, inst_needed}, 32'd1);
        check("post_rst_addr",  inst_addr_o,           32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
